axi_mem_window: RTL
===================

AXI_MEM_WINDOW -- requirements
Module: axi_mem_window

Interface
REQ-001 SHALL have parameters: ADDR_W=32 (address width); DATA_W=64 (data width); ID_W=6 (AXI ID width); WIN_LOG2=28 (window size, log2 bytes); IN_TAG=0 (upstream addr[ADDR_W-1:WIN_LOG2] decoded as in-window); OUT_TAG=1 (tag substituted on forward); MAX_OUT=8 (outstanding forwarded transactions per direction).
REQ-002 SHALL have one clock and an asynchronous active-low reset: clock  in  1  sole clock; reset_n  in  1  async assert, active-low.
REQ-003 s_aw_valid/ready, s_aw_addr[ADDR_W], s_aw_id[ID_W], s_aw_len[8], s_aw_size[3], s_aw_burst[2], cache[4], lock[1], prot[3], qos[4]  slave  upstream write address.
REQ-004 s_w_valid/ready, s_w_data[DATA_W], s_w_strb[DATA_W/8], s_w_last  slave  upstream write data.
REQ-005 s_b_valid/ready, s_b_id[ID_W], s_b_resp[2]  slave  upstream write response.
REQ-006 s_ar_* (same fields as s_aw_*)  slave  upstream read address.
REQ-007 s_r_valid/ready, s_r_id[ID_W], s_r_data[DATA_W], s_r_resp[2], s_r_last  slave  upstream read data.
REQ-008 m_aw_*, m_w_*, m_b_*, m_ar_*, m_r_*  master  mirror of REQ-003..007 toward the PS DRAM port.

Function
REQ-009 In-window SHALL mean addr[ADDR_W-1:WIN_LOG2]==IN_TAG on the start address only; the forwarded address SHALL be {OUT_TAG, addr[WIN_LOG2-1:0]}; other AW/AR fields SHALL pass unchanged.
REQ-010 Forwarding SHALL be combinational on valid/ready (zero-cycle latency) when permitted; otherwise s_*_ready=0 and m_*_valid=0.
REQ-011 rd_out SHALL increment on m_ar handshake, decrement on m_r handshake with rlast, and stay unchanged when both occur in one cycle; wr_out likewise with m_aw and m_b.
REQ-012 An in-window AR SHALL be forwarded only when rd_state=RD_IDLE and rd_out<MAX_OUT; an in-window AW only when wr_state=WR_IDLE and wr_out<MAX_OUT.
REQ-013 Read FSM SHALL have states RD_IDLE and RD_ERR. An out-of-window AR SHALL be accepted only when rd_out==0; id and len are latched and the FSM enters RD_ERR.
REQ-014 In RD_ERR, len+1 beats SHALL be emitted on s_r with resp=2'b11 (DECERR), data=0, and last on the final beat only; a beat advances on s_r handshake; the FSM returns to RD_IDLE after the last handshake.
REQ-015 wq_cnt (accepted forwarded AWs with W burst not yet complete) SHALL increment on forwarded AW accept and decrement on m_w handshake with last.
REQ-016 Write FSM SHALL have states WR_IDLE, WR_SINK and WR_ERRB. An out-of-window AW SHALL be accepted only when wr_out==0 and wq_cnt==0; it latches id and enters WR_SINK.
REQ-017 In WR_SINK, s_w_ready=1 and m_w_valid=0; on the s_w handshake with last, the FSM SHALL enter WR_ERRB. In WR_ERRB, s_b SHALL present resp=2'b11 with the latched id, then return to WR_IDLE on handshake.
REQ-018 Outside WR_SINK, W SHALL pass through only while wq_cnt>0; W beats arriving ahead of their AW SHALL be stalled (s_w_ready=0).
REQ-019 s_r/s_b SHALL be sourced from m_r/m_b in idle states and from the local generator otherwise; m_r_ready/m_b_ready SHALL be 0 in RD_ERR/WR_ERRB.
REQ-020 Upstream response order SHALL equal acceptance order, because the error path waits for the forwarded path to drain.
REQ-021 len=0 error read SHALL produce exactly one beat with last=1; len=255 SHALL produce 256 beats.
REQ-022 Simultaneous eligible AR and AW SHALL be handled independently in the same cycle.

Reset
REQ-023 While reset_n=0, all valid outputs, s_*_ready and m_*_ready SHALL be 0, counters SHALL be 0, FSMs SHALL be idle, and error data/resp SHALL be 0.
REQ-024 Reset mid-burst SHALL abort local error bursts immediately; the downstream port SHALL share the same reset domain.

Structure
REQ-025 Package axi_window_pkg SHALL hold the RESP_OKAY/RESP_DECERR constants and the rd_state/wr_state enums.
REQ-026 The read error beat generator SHALL be the sub-module axi_window_rd_err (latched id/len, beat counter, last generation).

Verification
REQ-027 AR addr=0x0000_1000, len=3 -> m_ar_addr=0x1000_1000; 4 R beats pass through with id preserved.
REQ-028 AR addr=0x2000_0000, id=5, len=3 with rd_out=0 -> 4 beats with resp=3, data=0, last on beat 4; m_ar_valid is never asserted.
REQ-029 2 forwarded ARs outstanding, then an out-of-window AR -> it is not accepted until the second forwarded rlast; the error beats follow.
REQ-030 Out-of-window AW id=2 len=1, then 2 W beats -> W is sunk; one B with id=2 resp=3; m_w_valid stays 0.
REQ-031 Issue MAX_OUT=8 forwarded AWs with downstream B stalled -> the 9th AW waits; the first m_b handshake admits it; wr_out never exceeds 8.
REQ-032 Assert reset_n=0 during the 2nd of 4 error read beats -> s_r_valid=0 the next cycle; after release, a new in-window AR is forwarded normally.

Source files
------------

// File: rtl/axi_window_pkg.sv
// axi_window_pkg: shared response codes and FSM state types for the AXI memory window
package axi_window_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_DECERR = 2'b11;

    typedef enum logic {RD_IDLE, RD_ERR} rd_state_e;
    typedef enum logic [1:0] {WR_IDLE, WR_SINK, WR_ERRB} wr_state_e;

endpackage

// File: rtl/axi_window_rd_err.sv
// axi_window_rd_err: local DECERR read burst generator for out-of-window reads
module axi_window_rd_err
    import axi_window_pkg::*;
#(
    parameter int ID_W = 6
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            i_start,
    input  logic [ID_W-1:0] i_id,
    input  logic [7:0]      i_len,
    input  logic            i_ready,
    output logic            o_busy,
    output logic            o_valid,
    output logic [ID_W-1:0] o_id,
    output logic            o_last,
    output logic [1:0]      o_resp
);

    rd_state_e       r_state;
    logic [ID_W-1:0] r_id;
    logic [7:0]      r_len;
    logic [7:0]      r_cnt;

    assign o_busy  = r_state == RD_ERR;
    assign o_valid = o_busy;
    assign o_id    = r_id;
    assign o_last  = o_busy && r_cnt == r_len;
    assign o_resp  = o_busy ? RESP_DECERR : RESP_OKAY;

    // Latch the rejected burst, then walk len+1 beats, one per upstream handshake
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state <= RD_IDLE;
            r_id    <= '0;
            r_len   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                RD_IDLE: if (i_start) begin
                    r_id    <= i_id;
                    r_len   <= i_len;
                    r_cnt   <= '0;
                    r_state <= RD_ERR;
                end
                RD_ERR: if (i_ready) begin
                    r_cnt   <= r_cnt + 8'd1;
                    r_state <= o_last ? RD_IDLE : RD_ERR;
                end
                default: r_state <= RD_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/axi_mem_window.sv
// axi_mem_window: retags in-window AXI bursts toward DRAM and answers the rest with DECERR
module axi_mem_window
    import axi_window_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 64,
    parameter int ID_W     = 6,
    parameter int WIN_LOG2 = 28,
    parameter int IN_TAG   = 0,
    parameter int OUT_TAG  = 1,
    parameter int MAX_OUT  = 8
) (
    input  logic                clock,
    input  logic                reset_n,
    input  logic                s_aw_valid,
    output logic                s_aw_ready,
    input  logic [ADDR_W-1:0]   s_aw_addr,
    input  logic [ID_W-1:0]     s_aw_id,
    input  logic [7:0]          s_aw_len,
    input  logic [2:0]          s_aw_size,
    input  logic [1:0]          s_aw_burst,
    input  logic [3:0]          s_aw_cache,
    input  logic                s_aw_lock,
    input  logic [2:0]          s_aw_prot,
    input  logic [3:0]          s_aw_qos,
    input  logic                s_w_valid,
    output logic                s_w_ready,
    input  logic [DATA_W-1:0]   s_w_data,
    input  logic [DATA_W/8-1:0] s_w_strb,
    input  logic                s_w_last,
    output logic                s_b_valid,
    input  logic                s_b_ready,
    output logic [ID_W-1:0]     s_b_id,
    output logic [1:0]          s_b_resp,
    input  logic                s_ar_valid,
    output logic                s_ar_ready,
    input  logic [ADDR_W-1:0]   s_ar_addr,
    input  logic [ID_W-1:0]     s_ar_id,
    input  logic [7:0]          s_ar_len,
    input  logic [2:0]          s_ar_size,
    input  logic [1:0]          s_ar_burst,
    input  logic [3:0]          s_ar_cache,
    input  logic                s_ar_lock,
    input  logic [2:0]          s_ar_prot,
    input  logic [3:0]          s_ar_qos,
    output logic                s_r_valid,
    input  logic                s_r_ready,
    output logic [ID_W-1:0]     s_r_id,
    output logic [DATA_W-1:0]   s_r_data,
    output logic [1:0]          s_r_resp,
    output logic                s_r_last,
    output logic                m_aw_valid,
    input  logic                m_aw_ready,
    output logic [ADDR_W-1:0]   m_aw_addr,
    output logic [ID_W-1:0]     m_aw_id,
    output logic [7:0]          m_aw_len,
    output logic [2:0]          m_aw_size,
    output logic [1:0]          m_aw_burst,
    output logic [3:0]          m_aw_cache,
    output logic                m_aw_lock,
    output logic [2:0]          m_aw_prot,
    output logic [3:0]          m_aw_qos,
    output logic                m_w_valid,
    input  logic                m_w_ready,
    output logic [DATA_W-1:0]   m_w_data,
    output logic [DATA_W/8-1:0] m_w_strb,
    output logic                m_w_last,
    input  logic                m_b_valid,
    output logic                m_b_ready,
    input  logic [ID_W-1:0]     m_b_id,
    input  logic [1:0]          m_b_resp,
    output logic                m_ar_valid,
    input  logic                m_ar_ready,
    output logic [ADDR_W-1:0]   m_ar_addr,
    output logic [ID_W-1:0]     m_ar_id,
    output logic [7:0]          m_ar_len,
    output logic [2:0]          m_ar_size,
    output logic [1:0]          m_ar_burst,
    output logic [3:0]          m_ar_cache,
    output logic                m_ar_lock,
    output logic [2:0]          m_ar_prot,
    output logic [3:0]          m_ar_qos,
    input  logic                m_r_valid,
    output logic                m_r_ready,
    input  logic [ID_W-1:0]     m_r_id,
    input  logic [DATA_W-1:0]   m_r_data,
    input  logic [1:0]          m_r_resp,
    input  logic                m_r_last
);

    localparam int TW = ADDR_W - WIN_LOG2;
    localparam int CW = $clog2(MAX_OUT + 1);
    localparam logic [TW-1:0] IN_T  = TW'(IN_TAG);
    localparam logic [TW-1:0] OUT_T = TW'(OUT_TAG);
    localparam logic [CW-1:0] MAX_C = CW'(MAX_OUT);

    logic [CW-1:0]   r_rd_out, r_wr_out, r_wq_cnt;
    wr_state_e       r_wr_state;
    logic [ID_W-1:0] r_b_id;
    logic            w_ar_in, w_aw_in, w_rd_err, w_ar_err;
    logic            w_aw_err, w_wr_idle, w_sink, w_errb, w_wq_nz;
    logic            w_e_valid, w_e_last;
    logic [ID_W-1:0] w_e_id;
    logic [1:0]      w_e_resp;

    assign w_ar_in = s_ar_addr[ADDR_W-1:WIN_LOG2] == IN_T;
    assign w_aw_in = s_aw_addr[ADDR_W-1:WIN_LOG2] == IN_T;

    assign m_ar_valid = reset_n && s_ar_valid && w_ar_in && !w_rd_err && r_rd_out < MAX_C;
    assign s_ar_ready = reset_n && !w_rd_err && (w_ar_in ? r_rd_out < MAX_C && m_ar_ready : r_rd_out == '0);
    assign w_ar_err   = reset_n && s_ar_valid && !w_ar_in && !w_rd_err && r_rd_out == '0;
    assign m_ar_addr  = {OUT_T, s_ar_addr[WIN_LOG2-1:0]};
    assign m_ar_id    = s_ar_id;
    assign m_ar_len   = s_ar_len;
    assign m_ar_size  = s_ar_size;
    assign m_ar_burst = s_ar_burst;
    assign m_ar_cache = s_ar_cache;
    assign m_ar_lock  = s_ar_lock;
    assign m_ar_prot  = s_ar_prot;
    assign m_ar_qos   = s_ar_qos;

    axi_window_rd_err #(.ID_W(ID_W)) u_rd_err (
        .clock   (clock),
        .reset_n (reset_n),
        .i_start (w_ar_err),
        .i_id    (s_ar_id),
        .i_len   (s_ar_len),
        .i_ready (s_r_ready),
        .o_busy  (w_rd_err),
        .o_valid (w_e_valid),
        .o_id    (w_e_id),
        .o_last  (w_e_last),
        .o_resp  (w_e_resp)
    );

    assign s_r_valid = w_rd_err ? w_e_valid : reset_n && m_r_valid;
    assign s_r_id    = w_rd_err ? w_e_id : m_r_id;
    assign s_r_data  = w_rd_err ? '0 : m_r_data;
    assign s_r_resp  = w_rd_err ? w_e_resp : m_r_resp;
    assign s_r_last  = w_rd_err ? w_e_last : m_r_last;
    assign m_r_ready = reset_n && !w_rd_err && s_r_ready;

    assign w_wr_idle  = r_wr_state == WR_IDLE;
    assign w_sink     = r_wr_state == WR_SINK;
    assign w_errb     = r_wr_state == WR_ERRB;
    assign w_wq_nz    = r_wq_cnt != '0;
    assign m_aw_valid = reset_n && s_aw_valid && w_aw_in && w_wr_idle && r_wr_out < MAX_C;
    assign s_aw_ready = reset_n && w_wr_idle && (w_aw_in ? r_wr_out < MAX_C && m_aw_ready : r_wr_out == '0 && !w_wq_nz);
    assign w_aw_err   = reset_n && s_aw_valid && !w_aw_in && w_wr_idle && r_wr_out == '0 && !w_wq_nz;
    assign m_aw_addr  = {OUT_T, s_aw_addr[WIN_LOG2-1:0]};
    assign m_aw_id    = s_aw_id;
    assign m_aw_len   = s_aw_len;
    assign m_aw_size  = s_aw_size;
    assign m_aw_burst = s_aw_burst;
    assign m_aw_cache = s_aw_cache;
    assign m_aw_lock  = s_aw_lock;
    assign m_aw_prot  = s_aw_prot;
    assign m_aw_qos   = s_aw_qos;

    assign s_w_ready = reset_n && (w_sink || (w_wq_nz && m_w_ready));
    assign m_w_valid = reset_n && !w_sink && w_wq_nz && s_w_valid;
    assign m_w_data  = s_w_data;
    assign m_w_strb  = s_w_strb;
    assign m_w_last  = s_w_last;

    assign s_b_valid = w_errb || (reset_n && m_b_valid);
    assign s_b_id    = w_errb ? r_b_id : m_b_id;
    assign s_b_resp  = w_errb ? RESP_DECERR : m_b_resp;
    assign m_b_ready = reset_n && !w_errb && s_b_ready;

    // Outstanding counters; simultaneous increment and decrement cancel out
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_rd_out <= '0;
            r_wr_out <= '0;
            r_wq_cnt <= '0;
        end else begin
            r_rd_out <= r_rd_out + CW'(m_ar_valid && m_ar_ready) - CW'(m_r_valid && m_r_ready && m_r_last);
            r_wr_out <= r_wr_out + CW'(m_aw_valid && m_aw_ready) - CW'(m_b_valid && m_b_ready);
            r_wq_cnt <= r_wq_cnt + CW'(m_aw_valid && m_aw_ready) - CW'(m_w_valid && m_w_ready && m_w_last);
        end
    end

    // Write error path: swallow the W burst of a rejected AW, then return one DECERR B
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_wr_state <= WR_IDLE;
            r_b_id     <= '0;
        end else begin
            case (r_wr_state)
                WR_IDLE: if (w_aw_err) begin
                    r_b_id     <= s_aw_id;
                    r_wr_state <= WR_SINK;
                end
                WR_SINK: if (s_w_valid && s_w_last) r_wr_state <= WR_ERRB;
                WR_ERRB: if (s_b_ready) r_wr_state <= WR_IDLE;
                default: r_wr_state <= WR_IDLE;
            endcase
        end
    end

endmodule
